// File: rtl/mips_defs.sv
// Shared MIPS decode definitions: opcode encodings, default widths, hazard FSM states.
package mips_defs;

    localparam int INST_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int RADDR_W_DEF = 5;
    localparam int OP_W        = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } hz_state_e;

endpackage

// File: rtl/id_decode.sv
// Pure combinational instruction decoder: opcode -> read enables, destination, immediate.
module id_decode
    import mips_defs::*;
#(
    parameter int INST_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic [INST_W-1:0]  inst,
    output logic [OP_W-1:0]    op,
    output logic [RADDR_W-1:0] rs,
    output logic [RADDR_W-1:0] rt,
    output logic [RADDR_W-1:0] dst,
    output logic               rd_a,
    output logic               rd_b,
    output logic               use_imm,
    output logic               wr,
    output logic               load,
    output logic               store,
    output logic [DATA_W-1:0]  imm
);

    logic [15:0] imm16;

    assign op    = inst[31:26];
    assign rs    = inst[21 +: RADDR_W];
    assign rt    = inst[16 +: RADDR_W];
    assign imm16 = inst[15:0];

    // Opcode table; unknown opcodes leave every control at 0 (NOP).
    always_comb begin
        rd_a    = 1'b0;
        rd_b    = 1'b0;
        use_imm = 1'b0;
        wr      = 1'b0;
        load    = 1'b0;
        store   = 1'b0;
        dst     = '0;
        imm     = '0;
        case (op)
            OP_RTYPE: begin
                rd_a = 1'b1;
                rd_b = 1'b1;
                wr   = 1'b1;
                dst  = inst[11 +: RADDR_W];
            end
            OP_ADDI: begin
                rd_a    = 1'b1;
                use_imm = 1'b1;
                wr      = 1'b1;
                dst     = rt;
                imm     = {{(DATA_W-16){imm16[15]}}, imm16};
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                rd_a    = 1'b1;
                use_imm = 1'b1;
                wr      = 1'b1;
                dst     = rt;
                imm     = DATA_W'(imm16);
            end
            OP_LUI: begin
                use_imm = 1'b1;
                wr      = 1'b1;
                dst     = rt;
                imm     = DATA_W'({imm16, 16'h0000});
            end
            OP_LW: begin
                rd_a    = 1'b1;
                use_imm = 1'b1;
                wr      = 1'b1;
                load    = 1'b1;
                dst     = rt;
                imm     = {{(DATA_W-16){imm16[15]}}, imm16};
            end
            OP_SW: begin
                rd_a    = 1'b1;
                rd_b    = 1'b1;
                use_imm = 1'b1;
                store   = 1'b1;
                imm     = {{(DATA_W-16){imm16[15]}}, imm16};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered decode stage: operand fetch with EX/MEM forwarding, load-use stall, ID/EX register.
module id_stage_pipe
    import mips_defs::*;
#(
    parameter int          INST_W  = 32,
    parameter int          DATA_W  = 32,
    parameter int          RADDR_W = 5,
    parameter int unsigned FWD_EN  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INST_W-1:0]  inst,
    input  logic               flush,
    output logic               regaRd,
    output logic               regbRd,
    output logic [RADDR_W-1:0] regaAddr,
    output logic [RADDR_W-1:0] regbAddr,
    input  logic [DATA_W-1:0]  regaData_i,
    input  logic [DATA_W-1:0]  regbData_i,
    input  logic               ex_wr,
    input  logic [RADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0]  ex_data,
    input  logic               ex_load,
    input  logic               mem_wr,
    input  logic [RADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0]  mem_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OP_W-1:0]    op,
    output logic [DATA_W-1:0]  regaData,
    output logic [DATA_W-1:0]  regbData,
    output logic [DATA_W-1:0]  stData,
    output logic               regcWr,
    output logic [RADDR_W-1:0] regcAddr,
    output logic               isLoad
);

    localparam bit FWD = (FWD_EN != 0);

    logic [OP_W-1:0]    dec_op;
    logic [RADDR_W-1:0] dec_rs, dec_rt, dec_dst;
    logic               dec_rd_a, dec_rd_b, dec_use_imm, dec_wr, dec_load, dec_store;
    logic [DATA_W-1:0]  dec_imm;
    logic [DATA_W-1:0]  val_a, val_b;
    logic               hazard, stall, advance, wr_eff;
    hz_state_e          state;

    id_decode #(
        .INST_W  (INST_W),
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W)
    ) u_decode (
        .inst    (inst),
        .op      (dec_op),
        .rs      (dec_rs),
        .rt      (dec_rt),
        .dst     (dec_dst),
        .rd_a    (dec_rd_a),
        .rd_b    (dec_rd_b),
        .use_imm (dec_use_imm),
        .wr      (dec_wr),
        .load    (dec_load),
        .store   (dec_store),
        .imm     (dec_imm)
    );

    assign regaRd   = dec_rd_a;
    assign regbRd   = dec_rd_b;
    assign regaAddr = dec_rs;
    assign regbAddr = dec_rt;

    // Operand resolution: $0 is hard zero, then EX (non-load) beats MEM beats register file.
    always_comb begin
        val_a = '0;
        val_b = '0;
        if (dec_rd_a && dec_rs != '0) begin
            if (FWD && ex_wr && !ex_load && dec_rs == ex_addr)
                val_a = ex_data;
            else if (FWD && mem_wr && dec_rs == mem_addr)
                val_a = mem_data;
            else
                val_a = regaData_i;
        end
        if (dec_rd_b && dec_rt != '0) begin
            if (FWD && ex_wr && !ex_load && dec_rt == ex_addr)
                val_b = ex_data;
            else if (FWD && mem_wr && dec_rt == mem_addr)
                val_b = mem_data;
            else
                val_b = regbData_i;
        end
    end

    assign hazard   = in_valid && ex_load && ex_wr && (ex_addr != '0) &&
                      ((dec_rd_a && dec_rs == ex_addr) || (dec_rd_b && dec_rt == ex_addr));
    assign stall    = hazard && !flush;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !stall;
    assign wr_eff   = dec_wr && (dec_dst != '0);

    // Hazard FSM and ID/EX register; a stalled slot drains as a bubble when EX accepts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            out_valid <= 1'b0;
            op        <= '0;
            regaData  <= '0;
            regbData  <= '0;
            stData    <= '0;
            regcWr    <= 1'b0;
            regcAddr  <= '0;
            isLoad    <= 1'b0;
        end else begin
            case (state)
                ST_RUN:   if (stall)  state <= ST_STALL;
                ST_STALL: if (!stall) state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
            if (flush) begin
                out_valid <= 1'b0;
            end else if (advance) begin
                if (in_valid && !stall) begin
                    out_valid <= 1'b1;
                    op        <= dec_op;
                    regaData  <= val_a;
                    regbData  <= dec_use_imm ? dec_imm : val_b;
                    stData    <= dec_store ? val_b : '0;
                    regcWr    <= wr_eff;
                    regcAddr  <= wr_eff ? dec_dst : '0;
                    isLoad    <= dec_load;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule
